// File: rtl/layer_fc_par.sv
// Fully-connected layer y = act(W*x + b) with P parallel MAC lanes.
// W and b are held in internal RAMs loaded through the config port while idle.
module layer_fc_par #(
  parameter int M    = 10,
  parameter int N    = 8,
  parameter int P    = 2,
  parameter int T    = 16,
  parameter int RELU = 1,
  parameter int SAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [T-1:0]           data_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [T-1:0]           data_out,
  input  logic                   cfg_wr_en,
  input  logic                   cfg_sel,
  input  logic [$clog2(M*N)-1:0] cfg_addr,
  input  logic [T-1:0]           cfg_data
);

  localparam int AW   = $clog2(M*N);
  localparam int BW   = (M > 1) ? $clog2(M) : 1;
  localparam int XW   = (N > 1) ? $clog2(N) : 1;
  localparam int CW   = $clog2(N + 2);
  localparam int G    = M / P;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int OW   = (P > 1) ? $clog2(P) : 1;
  localparam int AccW = 2*T + $clog2(N) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD_X  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  localparam logic signed [AccW-1:0] SatMax = {{(AccW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW-T+1){1'b1}}, {(T-1){1'b0}}};

  logic [T-1:0] wMem [M*N];
  logic [T-1:0] bMem [M];
  logic [T-1:0] xMem [N];

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] xAddr_q, xAddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] g_q, g_d;
  logic [OW-1:0] oIdx_q, oIdx_d;

  logic                   rdValid_q, prodValid_q;
  logic [T-1:0]           wRd_q   [P];
  logic [T-1:0]           xRd_q;
  logic signed [2*T-1:0]  prod_q  [P];
  logic signed [AccW-1:0] acc_q   [P];
  logic [T-1:0]           outBuf_q[P];

  logic [AW-1:0]          wIdx    [P];
  logic [BW-1:0]          bIdx    [P];
  logic signed [AccW-1:0] accSum  [P];
  logic signed [AccW-1:0] clipped [P];
  logic [T-1:0]           result  [P];

  logic xAccept, issue, computeStart, lastCompute;

  assign s_ready      = !reset && (state_q == IDLE || state_q == LOAD_X);
  assign m_valid      = (state_q == OUTPUT);
  assign data_out     = m_valid ? outBuf_q[oIdx_q] : '0;
  assign xAccept      = s_valid && s_ready;
  assign issue        = (state_q == COMPUTE) && (cnt_q < CW'(N));
  assign computeStart = (state_q == COMPUTE) && (cnt_q == '0);
  assign lastCompute  = (state_q == COMPUTE) && (cnt_q == CW'(N + 1));

  always_comb begin
    state_d = state_q;
    xAddr_d = xAddr_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    oIdx_d  = oIdx_q;
    case (state_q)
      IDLE: begin
        if (xAccept) begin
          if (N == 1) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            g_d     = '0;
          end else begin
            state_d = LOAD_X;
            xAddr_d = XW'(1);
          end
        end
      end
      LOAD_X: begin
        if (xAccept) begin
          if (xAddr_q == XW'(N - 1)) begin
            state_d = COMPUTE;
            xAddr_d = '0;
            cnt_d   = '0;
            g_d     = '0;
          end else begin
            xAddr_d = xAddr_q + XW'(1);
          end
        end
      end
      COMPUTE: begin
        // N issue cycles, then two more for the product and accumulate stages.
        if (lastCompute) begin
          state_d = OUTPUT;
          oIdx_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          if (oIdx_q == OW'(P - 1)) begin
            if (g_q == GW'(G - 1)) begin
              state_d = IDLE;
              g_d     = '0;
            end else begin
              state_d = COMPUTE;
              g_d     = g_q + GW'(1);
              cnt_d   = '0;
            end
          end else begin
            oIdx_d = oIdx_q + OW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xAddr_q <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      oIdx_q  <= '0;
    end else begin
      state_q <= state_d;
      xAddr_q <= xAddr_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      oIdx_q  <= oIdx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xAccept) xMem[xAddr_q] <= data_in;
  end

  // Config port is live only while idle; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && cfg_wr_en) begin
      if (!cfg_sel && int'(cfg_addr) < M*N) begin
        wMem[cfg_addr] <= cfg_data;
      end else if (cfg_sel && int'(cfg_addr) < M) begin
        bMem[BW'(cfg_addr)] <= cfg_data;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < P; p++) begin
      wIdx[p] = AW'((int'(g_q) * P + p) * N + int'(cnt_q));
      bIdx[p] = BW'(int'(g_q) * P + p);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      xRd_q <= xMem[XW'(cnt_q)];
      for (int p = 0; p < P; p++) wRd_q[p] <= wMem[wIdx[p]];
    end
    for (int p = 0; p < P; p++) begin
      prod_q[p] <= $signed({{T{wRd_q[p][T-1]}}, wRd_q[p]}) * $signed({{T{xRd_q[T-1]}}, xRd_q});
    end
  end

  // ReLU first, then saturate or wrap to T bits.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      accSum[p]  = acc_q[p] + {{(AccW-2*T){prod_q[p][2*T-1]}}, prod_q[p]};
      clipped[p] = accSum[p];
      if (RELU != 0 && accSum[p][AccW-1]) clipped[p] = '0;
      if (SAT != 0 && clipped[p] > SatMax) clipped[p] = SatMax;
      else if (SAT != 0 && clipped[p] < SatMin) clipped[p] = SatMin;
      result[p] = clipped[p][T-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid_q   <= 1'b0;
      prodValid_q <= 1'b0;
      for (int p = 0; p < P; p++) begin
        acc_q[p]    <= '0;
        outBuf_q[p] <= '0;
      end
    end else begin
      rdValid_q   <= issue;
      prodValid_q <= rdValid_q;
      for (int p = 0; p < P; p++) begin
        if (computeStart) begin
          acc_q[p] <= {{(AccW-T){bMem[bIdx[p]][T-1]}}, bMem[bIdx[p]]};
        end else if (prodValid_q) begin
          acc_q[p] <= accSum[p];
        end
        if (lastCompute) outBuf_q[p] <= result[p];
      end
    end
  end

endmodule

// File: tb/tb_layer_fc_par.sv
// Bench for layer_fc_par: two instances (ReLU+saturate, plain wrap) fed the same
// stimulus and checked against an arithmetic model of the layer.
module tb_layer_fc_par;

  localparam int M  = 4;
  localparam int N  = 3;
  localparam int P  = 2;
  localparam int T  = 16;
  localparam int AW = $clog2(M*N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic [T-1:0]  data_in = '0;
  logic          m_ready = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [T-1:0]  cfg_data = '0;

  logic          sReadyA, sReadyB, mValidA, mValidB;
  logic [T-1:0]  dataA, dataB;

  always #5 clk = ~clk;

  layer_fc_par #(.M(M), .N(N), .P(P), .T(T), .RELU(1), .SAT(1)) dutA (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(sReadyA), .data_in(data_in),
    .m_valid(mValidA), .m_ready(m_ready), .data_out(dataA), .cfg_wr_en(cfg_wr_en),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data));

  layer_fc_par #(.M(M), .N(N), .P(P), .T(T), .RELU(0), .SAT(0)) dutB (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(sReadyB), .data_in(data_in),
    .m_valid(mValidB), .m_ready(m_ready), .data_out(dataB), .cfg_wr_en(cfg_wr_en),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data));

  typedef struct {
    logic [T-1:0] a;
    logic [T-1:0] b;
    bit           last;
  } exp_t;

  exp_t         expQ[$];
  logic [T-1:0] capA[$];
  logic [T-1:0] capB[$];
  int           modelW[M*N];
  int           modelB[M];
  int           compared = 0;
  int           mismatched = 0;
  int           cycleCnt = 0;
  int           acceptCycle = 0;
  int           firstRise = -1;
  bit           inFlight = 0;
  bit           checkEn = 0;
  bit           prevMv = 0;
  bit           prevHeld = 0;
  int           vecA[N];
  int           vecB[N];
  int           lits[2*M];

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [T-1:0] actA(input longint s);
    longint v = s;
    if (v < 0) v = 0;
    if (v > (64'sd1 <<< (T-1)) - 1) v = (64'sd1 <<< (T-1)) - 1;
    return v[T-1:0];
  endfunction

  function automatic logic [T-1:0] actB(input longint s);
    return s[T-1:0];
  endfunction

  task automatic pushExpected(input int x[N]);
    exp_t e;
    for (int r = 0; r < M; r++) begin
      longint s = longint'(modelB[r]);
      for (int c = 0; c < N; c++) s += longint'(modelW[r*N+c]) * longint'(x[c]);
      e.a = actA(s);
      e.b = actB(s);
      e.last = (r == M-1);
      expQ.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the rising edge that took the write.
  task automatic cfgWrite(input bit sel, input int addr, input int val, input bit effective);
    cfg_wr_en = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = AW'(addr);
    cfg_data  = T'(val);
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    if (effective) begin
      if (!sel) modelW[addr] = val;
      else      modelB[addr] = val;
    end
  endtask

  task automatic applyStimulus(input int x[N], input bit keepValid, input bit withCfg,
                               input bit cSel, input int cAddr, input int cVal);
    bit accepted;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      data_in = T'(x[i]);
      if (i == 0 && withCfg) begin
        cfg_wr_en = 1'b1;
        cfg_sel   = cSel;
        cfg_addr  = AW'(cAddr);
        cfg_data  = T'(cVal);
      end
      accepted = 1'b0;
      for (int k = 0; k < 200 && !accepted; k++) begin
        @(negedge clk);
        accepted = sReadyA;
        if (accepted && i == N-1) acceptCycle = cycleCnt;
        @(posedge clk);
        #1;
      end
      if (i == 0 && withCfg) begin
        cfg_wr_en = 1'b0;
        if (!cSel) modelW[cAddr] = cVal;
        else       modelB[cAddr] = cVal;
      end
      if (!accepted) begin
        failNow("xAccept");
        s_valid = 1'b0;
        return;
      end
    end
    pushExpected(x);
    inFlight  = 1'b1;
    firstRise = -1;
    if (!keepValid) s_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 300 && expQ.size() != 0; k++) @(posedge clk);
    if (expQ.size() != 0) failNow("drain");
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of both instances against the model queue.
  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("sReadyA", sReadyA, !inFlight);
      checkOutput("sReadyB", sReadyB, !inFlight);
      if (prevHeld) checkOutput("holdValid", mValidA, 1);
      if (mValidA && !prevMv && firstRise < 0) firstRise = cycleCnt;
      if (mValidA) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", mValidA, 0);
        end else begin
          checkOutput("yA", dataA, expQ[0].a);
          checkOutput("yB", dataB, expQ[0].b);
          checkOutput("mValidB", mValidB, 1);
          if (m_ready) begin
            capA.push_back(dataA);
            capB.push_back(dataB);
            if (expQ[0].last) inFlight = 1'b0;
            expQ.delete(0);
          end
        end
      end
      prevMv   = mValidA;
      prevHeld = mValidA && !m_ready;
    end else begin
      prevMv   = 1'b0;
      prevHeld = 1'b0;
    end
  end

  initial begin
    #200000;
    failNow("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstSReady", sReadyA, 0);
    checkOutput("rstMValid", mValidA, 0);
    checkOutput("rstData", dataA, 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    checkEn = 1'b1;

    // Basic function and latency: W all 1, b = r.
    for (int i = 0; i < M*N; i++) cfgWrite(1'b0, i, 1, 1'b1);
    for (int r = 0; r < M; r++) cfgWrite(1'b1, r, r, 1'b1);
    capA.delete(); capB.delete();
    vecA = '{1, 2, 3};
    applyStimulus(vecA, 1'b0, 1'b0, 1'b0, 0, 0);
    waitDrain();
    checkOutput("basicCount", capA.size(), M);
    for (int i = 0; i < capA.size() && i < M; i++) begin
      checkOutput("basicA", capA[i], 6 + i);
      checkOutput("basicB", capB[i], 6 + i);
    end
    checkOutput("latency", firstRise - acceptCycle, N + 3);

    // Negative result: ReLU clamps, wrap keeps two's complement.
    cfgWrite(1'b1, 0, -10, 1'b1);
    capA.delete(); capB.delete();
    applyStimulus(vecA, 1'b0, 1'b0, 1'b0, 0, 0);
    waitDrain();
    if (capA.size() > 0) begin
      checkOutput("reluA", capA[0], 0);
      checkOutput("reluB", capB[0], 16'hFFFC);
    end else failNow("reluNoOutput");

    // Overflow plus 5-cycle backpressure in mid-stream.
    cfgWrite(1'b1, 0, 0, 1'b1);
    for (int c = 0; c < N; c++) cfgWrite(1'b0, c, 32767, 1'b1);
    capA.delete(); capB.delete();
    vecA = '{32767, 32767, 32767};
    applyStimulus(vecA, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 100 && expQ.size() > M-1; k++) @(posedge clk);
    if (expQ.size() > M-1) failNow("stallStart");
    #1;
    m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    m_ready = 1'b1;
    waitDrain();
    checkOutput("satCount", capA.size(), M);
    if (capA.size() > 1) begin
      checkOutput("satA0", capA[0], 32767);
      checkOutput("satB0", capB[0], 16'h0003);
      checkOutput("satA1", capA[1], 32767);
      checkOutput("satB1", capB[1], 16'h7FFE);
    end

    // Reset during group-1 compute; config must survive.
    for (int c = 0; c < N; c++) cfgWrite(1'b0, c, 1, 1'b1);
    for (int r = 0; r < M; r++) cfgWrite(1'b1, r, 0, 1'b1);
    vecA = '{1, 2, 3};
    applyStimulus(vecA, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 100 && expQ.size() > M-P; k++) @(posedge clk);
    if (expQ.size() > M-P) failNow("group0Drain");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstSReady", sReadyA, 0);
    expQ.delete();
    inFlight = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstMValid", mValidA, 0);
    checkOutput("midRstData", dataA, 0);
    checkOutput("midRstSReadyUp", sReadyA, 1);
    @(posedge clk);
    #1;
    capA.delete(); capB.delete();
    vecA = '{1, 1, 1};
    applyStimulus(vecA, 1'b0, 1'b0, 1'b0, 0, 0);
    waitDrain();
    checkOutput("postRstCount", capA.size(), M);
    for (int i = 0; i < capA.size() && i < M; i++) checkOutput("postRstA", capA[i], 3);

    // Back-to-back vectors with s_valid held, plus an ignored write during COMPUTE.
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) cfgWrite(1'b0, r*N + c, r + c + 1, 1'b1);
    for (int r = 0; r < M; r++) cfgWrite(1'b1, r, r, 1'b1);
    capA.delete(); capB.delete();
    vecA = '{1, 2, 3};
    vecB = '{2, -1, 4};
    fork
      begin
        applyStimulus(vecA, 1'b1, 1'b0, 1'b0, 0, 0);
        applyStimulus(vecB, 1'b0, 1'b0, 1'b0, 0, 0);
      end
      begin
        for (int k = 0; k < 100 && !inFlight; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        cfgWrite(1'b0, 0, 99, 1'b0);
      end
    join
    waitDrain();
    lits = '{14, 21, 28, 35, 12, 18, 24, 30};
    checkOutput("b2bCount", capA.size(), 2*M);
    for (int i = 0; i < capA.size() && i < 2*M; i++) checkOutput("b2bA", capA[i], lits[i]);

    // Out-of-range writes dropped; write alongside x[0] is seen by that vector.
    cfgWrite(1'b1, 5, 1000, 1'b0);
    cfgWrite(1'b0, 13, 500, 1'b0);
    capA.delete(); capB.delete();
    vecA = '{1, 0, 0};
    applyStimulus(vecA, 1'b0, 1'b1, 1'b1, 3, 50);
    waitDrain();
    lits[0:3] = '{1, 3, 5, 54};
    checkOutput("cfgCount", capA.size(), M);
    for (int i = 0; i < capA.size() && i < M; i++) checkOutput("cfgA", capA[i], lits[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
